// File: rtl/axis_packet_injector_pkg.sv
// Shared definitions for the AXI-Stream packet injector: register map,
// CTRL/STATUS bit positions, FSM state type and the egress bundle types.
package axis_packet_injector_pkg;

   localparam int INJ_DATA_WIDTH = 16;
   localparam int INJ_DEST_WIDTH = 2;

   localparam logic [7:0] INJ_REG_DATA_LO    = 8'h00;
   localparam logic [7:0] INJ_REG_DATA_HI    = 8'h01;
   localparam logic [7:0] INJ_REG_CTRL       = 8'h02;
   localparam logic [7:0] INJ_REG_STATUS     = 8'h03;
   localparam logic [7:0] INJ_REG_LEVEL      = 8'h04;
   localparam logic [7:0] INJ_REG_PKT_CNT_LO = 8'h05;
   localparam logic [7:0] INJ_REG_PKT_CNT_HI = 8'h06;

   localparam int INJ_CTRL_DEST_LSB = 0;
   localparam int INJ_CTRL_START    = 2;
   localparam int INJ_CTRL_IRQ_EN   = 3;
   localparam int INJ_CTRL_FLUSH    = 4;

   localparam int INJ_STATUS_BUSY  = 0;
   localparam int INJ_STATUS_FULL  = 1;
   localparam int INJ_STATUS_EMPTY = 2;
   localparam int INJ_STATUS_DONE  = 3;
   localparam int INJ_STATUS_OVF   = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } inj_state_t;

   typedef struct packed {
      logic [INJ_DATA_WIDTH-1:0] tdata;
      logic                      tvalid;
      logic                      tlast;
      logic [INJ_DEST_WIDTH-1:0] tdest;
   } axis_d_source_t;

   typedef struct packed {
      logic tready;
   } axis_d_sink_t;

endpackage

// File: rtl/axis_packet_injector_fifo.sv
// Synchronous beat FIFO for the packet injector. The head word is held in a
// register so the egress data comes straight from a flop and stays stable
// while the consumer stalls. A push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module pkt_injector_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     push_ok
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    rd_next;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rd_next = rd_ptr_q + 1'b1;
   assign head    = head_q;
   assign count   = count_q;

   // Next pointers, occupancy and head word; the head is refilled from the
   // slot behind it on a pop, or from the incoming word when it is the only one.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_next;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (pop_ok) begin
            if (count_q > (AW+1)'(1)) head_d = mem_q[rd_next];
            else if (push_ok)         head_d = push_data;
         end else if (push_ok && empty) begin
            head_d = push_data;
         end
      end
   end

   // Storage array write port; contents need no reset because occupancy gates use.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   // Pointer, occupancy and head registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/axis_packet_injector.sv
// Software-driven AXI-Stream packet injector. The host fills a beat FIFO over
// an 8-bit Avalon-MM slave, then starts a packet; every beat buffered at start
// goes out as one packet with a fixed tdest and tlast on the final beat.
// Optional build macro PKT_INJECTOR_PKT_CNT_EN adds a 16-bit sent-packet
// counter at 0x05/0x06.
module axis_packet_injector
   import axis_packet_injector_pkg::*;
#(
   parameter int DATA_WIDTH = INJ_DATA_WIDTH,
   parameter int DEST_WIDTH = INJ_DEST_WIDTH,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            writedata,
   input  logic                  write,
   input  logic                  chipselect,
   input  logic [7:0]            address,
   input  logic                  read,
   output logic [7:0]            readdata,
   output logic [DATA_WIDTH-1:0] egress_tdata,
   output logic                  egress_tvalid,
   input  logic                  egress_tready,
   output logic                  egress_tlast,
   output logic [DEST_WIDTH-1:0] egress_tdest,
   output logic                  irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [0:0] ST_IDLE = 1'(IDLE);
   localparam logic [0:0] ST_SEND = 1'(SEND);

   logic [0:0]            state_q, state_d;
   logic [CW-1:0]         remaining_q, remaining_d;
   logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic                  irq_en_q, irq_en_d;
   logic                  done_q, done_d;
   logic                  ovf_q, ovf_d;
   logic [7:0]            staging_q, staging_d;
   logic [7:0]            readdata_q, readdata_d;

   logic                  wr_en, rd_en, wr_hi, wr_ctrl, wr_status;
   logic                  fifo_flush, fifo_full, fifo_empty, fifo_push_ok;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [CW-1:0]         fifo_count;
   logic                  fire, last_beat, busy;
   logic [7:0]            level, ctrl_rd, status_rd, cnt_lo_rd, cnt_hi_rd;

   axis_d_source_t egress_src;
   axis_d_sink_t   egress_snk;

   assign wr_en     = chipselect && write;
   assign rd_en     = chipselect && read;
   assign wr_hi     = wr_en && (address == INJ_REG_DATA_HI);
   assign wr_ctrl   = wr_en && (address == INJ_REG_CTRL);
   assign wr_status = wr_en && (address == INJ_REG_STATUS);

   assign busy       = (state_q == ST_SEND);
   assign last_beat  = busy && (remaining_q == CW'(1));
   assign egress_snk = '{tready: egress_tready};
   assign egress_src = '{tdata: fifo_head, tvalid: busy, tlast: last_beat, tdest: tdest_q};
   assign fire       = egress_src.tvalid && egress_snk.tready;

   assign egress_tdata  = egress_src.tdata;
   assign egress_tvalid = egress_src.tvalid;
   assign egress_tlast  = egress_src.tlast;
   assign egress_tdest  = egress_src.tdest;
   assign readdata      = readdata_q;
   assign irq           = done_q && irq_en_q;

   pkt_injector_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (wr_hi),
      .push_data (DATA_WIDTH'({writedata, staging_q})),
      .pop       (fire),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .push_ok   (fifo_push_ok)
   );

   assign level = (32'(fifo_count) > 32'd255) ? 8'hFF : 8'(fifo_count);

`ifdef PKT_INJECTOR_PKT_CNT_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [7:0]  cnt_hi_snap_q, cnt_hi_snap_d;

   // Packet counter: cleared by any write to the low byte, bumped on each
   // tlast handshake; reading the low byte freezes the high byte for 0x06.
   always_comb begin
      pkt_cnt_d     = pkt_cnt_q;
      cnt_hi_snap_d = cnt_hi_snap_q;
      if (wr_en && (address == INJ_REG_PKT_CNT_LO)) pkt_cnt_d = '0;
      else if (fire && last_beat)                   pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (rd_en && (address == INJ_REG_PKT_CNT_LO)) cnt_hi_snap_d = pkt_cnt_q[15:8];
   end

   // Packet counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_cnt_q     <= '0;
         cnt_hi_snap_q <= '0;
      end else begin
         pkt_cnt_q     <= pkt_cnt_d;
         cnt_hi_snap_q <= cnt_hi_snap_d;
      end
   end

   assign cnt_lo_rd = pkt_cnt_q[7:0];
   assign cnt_hi_rd = cnt_hi_snap_q;
`else
   assign cnt_lo_rd = 8'h00;
   assign cnt_hi_rd = 8'h00;
`endif

   // Register readback values assembled from live state.
   always_comb begin
      ctrl_rd                           = '0;
      ctrl_rd[DEST_WIDTH-1:0]           = dest_q;
      ctrl_rd[INJ_CTRL_IRQ_EN]          = irq_en_q;
      status_rd                         = '0;
      status_rd[INJ_STATUS_BUSY]        = busy;
      status_rd[INJ_STATUS_FULL]        = fifo_full;
      status_rd[INJ_STATUS_EMPTY]       = fifo_empty;
      status_rd[INJ_STATUS_DONE]        = done_q;
      status_rd[INJ_STATUS_OVF]         = ovf_q;
   end

   // Host register writes, sticky flags, packet FSM and registered reads.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      tdest_d     = tdest_q;
      dest_d      = dest_q;
      irq_en_d    = irq_en_q;
      done_d      = done_q;
      ovf_d       = ovf_q;
      staging_d   = staging_q;
      readdata_d  = readdata_q;
      fifo_flush  = 1'b0;

      if (wr_en && (address == INJ_REG_DATA_LO)) staging_d = writedata;
      if (wr_ctrl) begin
         dest_d   = writedata[DEST_WIDTH-1:0];
         irq_en_d = writedata[INJ_CTRL_IRQ_EN];
      end
      if (wr_status && writedata[INJ_STATUS_DONE]) done_d = 1'b0;
      if (wr_status && writedata[INJ_STATUS_OVF])  ovf_d  = 1'b0;
      if (wr_hi && !fifo_push_ok)                  ovf_d  = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (wr_ctrl && writedata[INJ_CTRL_FLUSH]) begin
               fifo_flush = 1'b1;
            end else if (wr_ctrl && writedata[INJ_CTRL_START] && !fifo_empty) begin
               remaining_d = fifo_count;
               tdest_d     = writedata[DEST_WIDTH-1:0];
               state_d     = ST_SEND;
            end
         end
         default: begin
            if (fire) begin
               remaining_d = remaining_q - 1'b1;
               if (last_beat) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
      endcase

      if (rd_en) begin
         case (address)
            INJ_REG_CTRL:       readdata_d = ctrl_rd;
            INJ_REG_STATUS:     readdata_d = status_rd;
            INJ_REG_LEVEL:      readdata_d = level;
            INJ_REG_PKT_CNT_LO: readdata_d = cnt_lo_rd;
            INJ_REG_PKT_CNT_HI: readdata_d = cnt_hi_rd;
            default:            readdata_d = 8'h00;
         endcase
      end
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         tdest_q     <= '0;
         dest_q      <= '0;
         irq_en_q    <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         staging_q   <= '0;
         readdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         tdest_q     <= tdest_d;
         dest_q      <= dest_d;
         irq_en_q    <= irq_en_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         staging_q   <= staging_d;
         readdata_q  <= readdata_d;
      end
   end

endmodule

// File: doc/axis_packet_injector.md
Name: axis_packet_injector

Overview:
- Software-driven AXI-Stream transmitter that feeds one packet switch ingress port, such as ingress port 0.
- The host pushes 16-bit beats over the 8-bit Avalon-MM slave into an internal FIFO, then sets tdest and issues start.
- The block emits the buffered beats as one AXIS packet with tdest and tlast, then raises done and an optional irq.
- Used for bring-up and loopback testing of the switch without external traffic.

Parameters:
- DATA_WIDTH, 16, AXIS tdata width; fixed at 16 to match switch ingress.
- DEST_WIDTH, 2, AXIS tdest width; equals log2 of the number of egress ports.
- FIFO_DEPTH, 64, beat capacity; power of two, minimum 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- writedata  in  8  Avalon write data
- write  in  1  Avalon write strobe
- chipselect  in  1  Avalon select
- address  in  8  register byte address
- read  in  1  Avalon read strobe
- readdata  out  8  registered read data
- egress_tdata  out  DATA_WIDTH  beat to switch ingress
- egress_tvalid  out  1  beat valid
- egress_tready  in  1  switch ready
- egress_tlast  out  1  final beat of packet
- egress_tdest  out  DEST_WIDTH  destination egress port
- irq  out  1  level interrupt

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: readdata=0, tvalid=0, tlast=0, tdata=0, tdest=0, irq=0. FIFO is emptied, all flags are cleared, FSM goes to IDLE.
- Register map (accesses require chipselect):
  - 0x00 DATA_LO, W: loads an 8-bit staging register.
  - 0x01 DATA_HI, W: pushes {writedata, staging} as one beat.
    - If the FIFO is full, the beat is dropped and STATUS.ovf is set.
  - 0x02 CTRL, RW:
    - [1:0] dest
    - [2] start, write-only, self-clearing
    - [3] irq_en
    - [4] flush, write-only
    - Reads return {3'b0, 1'b0, irq_en, 1'b0, dest}.
  - 0x03 STATUS, R: [0] busy, [1] full, [2] empty, [3] done, [4] ovf. Writing 1 to bit 3 or bit 4 clears that bit (W1C).
  - 0x04 LEVEL, R: FIFO occupancy, saturating display at 255.
- Reads: readdata updates on the clock edge after chipselect&&read. Unmapped addresses read 0; writes to them are ignored.
- FSM states:
  - IDLE:
    - A start write with FIFO not empty latches remaining = occupancy and tdest = CTRL.dest, then moves to SEND on the next edge.
    - A start write with FIFO empty is ignored and done is not set.
    - A flush write empties the FIFO.
  - SEND:
    - tvalid=1; tdata = FIFO head; tlast = (remaining==1); tdest is held for the whole packet.
    - On tvalid&&tready: pop the FIFO and decrement remaining.
    - On the pop with tlast: go to IDLE and set done. tvalid drops on the following cycle, so packets are never back-to-back.
- Handshake:
  - tdata, tlast and tdest stay stable while tvalid&&!tready.
  - tvalid never deasserts before acceptance, except on reset.
  - One beat transfers per accepted cycle with no bubbles, so throughput is 1 beat/clk when tready is held high.
- Events while busy:
  - DATA_HI pushes are accepted but belong to the next packet, because remaining was latched at start.
  - start and flush are ignored.
  - A CTRL.dest write only updates the register; the active tdest is unchanged.
- Simultaneous push and pop in the same cycle: occupancy is unchanged. A push is accepted when full only if a pop occurs in the same cycle.
- irq = done && irq_en, combinational from registers.
- Reset mid-packet: tvalid drops after the reset edge and the partial packet is abandoned without tlast. This is accepted behaviour; the switch is reset on the same domain.

Optional Feature:
- Macro: PKT_INJECTOR_PKT_CNT_EN.
- When defined:
  - A 16-bit transmitted-packet counter increments on each tlast handshake and wraps 0xFFFF to 0.
  - 0x05 reads the low byte of the counter; 0x06 reads the high byte.
  - A read of 0x05 snapshots the high byte so 0x06 returns a coherent value.
  - Writing any value to 0x05 clears the counter.
- When undefined: 0x05 and 0x06 read 0 and no counter logic is built.

Decomposition:
- Shared package contents:
  - register address constants (INJ_REG_DATA_LO through INJ_REG_PKT_CNT_HI)
  - CTRL and STATUS bit-index constants
  - the FSM state enum inj_state_t {IDLE, SEND}
  - DATA_WIDTH and DEST_WIDTH defaults
- The existing axis_d_source_t and axis_d_sink_t typedefs are reused for the egress bundle.
- One sub-module: pkt_injector_fifo, a synchronous FIFO with the head word registered, count output and full/empty flags.

Test Plan:
1. Push 0x1234, 0xABCD, 0x0001, set dest=2, start, tready=1 -> three consecutive beats 0x1234, 0xABCD, 0x0001, tdest=2, tlast on beat 3 only, then STATUS=0x0C (done, empty).
2. Same packet with tready toggling 1,0,0,1,0,1 -> tdata/tlast/tdest are held during stalls and exactly 3 handshakes occur.
3. Push 65 beats into FIFO_DEPTH=64 -> LEVEL=64, full=1, ovf=1; after start and drain, the 64th beat carries tlast and the 65th value never appears.
4. Start with empty FIFO -> no tvalid for 10 cycles, done=0. Then irq_en=1 plus a 1-beat packet -> irq=1 after tlast; W1C to STATUS bit3 -> irq=0.
5. During SEND of a 4-beat packet, push 2 beats and write start -> only 4 beats with tlast; LEVEL=2 afterwards; a second start sends exactly 2.
6. Assert reset on beat 2 of 4 -> next cycle tvalid=0, LEVEL=0, readdata=0, irq=0. With PKT_INJECTOR_PKT_CNT_EN, three packets -> 0x05 reads 3, 0x06 reads 0.
